// File: rtl/e203_irq_arb_pkg.sv
// Shared types and constants for the e203 interrupt arbiter.
package e203_irq_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  localparam logic [3:0] CAUSE_MEI  = 4'd11;
  localparam logic [3:0] CAUSE_MSI  = 4'd3;
  localparam logic [3:0] CAUSE_MTI  = 4'd7;
  localparam logic [3:0] CAUSE_NONE = 4'd0;

  localparam int unsigned SRC_TMR = 0;
  localparam int unsigned SRC_SFT = 1;
  localparam int unsigned SRC_EXT = 2;
  localparam int unsigned SRC_DBG = 3;

  // Recovers the one-hot source of a latched request from its cause/is_dbg pair.
  function automatic logic [3:0] src_mask(input logic is_dbg, input logic [3:0] cause);
    logic [3:0] m;
    m = '0;
    if (is_dbg) begin
      m[SRC_DBG] = 1'b1;
    end else begin
      case (cause)
        CAUSE_MEI: m[SRC_EXT] = 1'b1;
        CAUSE_MSI: m[SRC_SFT] = 1'b1;
        CAUSE_MTI: m[SRC_TMR] = 1'b1;
        default:   m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/e203_irq_arbiter_if.sv
// Interrupt lines, enables and request handshake between sync stage/core and arbiter.
interface e203_irq_arbiter_if;
  logic       dbg_irq_r;
  logic       ext_irq_r;
  logic       sft_irq_r;
  logic       tmr_irq_r;
  logic       mstatus_mie;
  logic       mie_meie;
  logic       mie_msie;
  logic       mie_mtie;
  logic       dbg_mode;
  logic       irq_ack;
  logic       irq_req;
  logic       irq_is_dbg;
  logic [3:0] irq_cause;

  modport slave (
    input  dbg_irq_r, ext_irq_r, sft_irq_r, tmr_irq_r,
    input  mstatus_mie, mie_meie, mie_msie, mie_mtie,
    input  dbg_mode, irq_ack,
    output irq_req, irq_is_dbg, irq_cause
  );

  modport master (
    output dbg_irq_r, ext_irq_r, sft_irq_r, tmr_irq_r,
    output mstatus_mie, mie_meie, mie_msie, mie_mtie,
    output dbg_mode, irq_ack,
    input  irq_req, irq_is_dbg, irq_cause
  );
endinterface

// File: rtl/e203_irq_prio_sel.sv
// Fixed-priority selector: dbg > ext > sft > tmr, one-hot grant plus cause code.
module e203_irq_prio_sel
  import e203_irq_arb_pkg::*;
(
  input  logic [3:0] elig_i,
  output logic [3:0] grant_o,
  output logic [3:0] cause_o,
  output logic       is_dbg_o
);

  always_comb begin
    grant_o  = '0;
    cause_o  = CAUSE_NONE;
    is_dbg_o = 1'b0;
    if (elig_i[SRC_DBG]) begin
      grant_o[SRC_DBG] = 1'b1;
      is_dbg_o         = 1'b1;
    end else if (elig_i[SRC_EXT]) begin
      grant_o[SRC_EXT] = 1'b1;
      cause_o          = CAUSE_MEI;
    end else if (elig_i[SRC_SFT]) begin
      grant_o[SRC_SFT] = 1'b1;
      cause_o          = CAUSE_MSI;
    end else if (elig_i[SRC_TMR]) begin
      grant_o[SRC_TMR] = 1'b1;
      cause_o          = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/e203_irq_arbiter.sv
// Interrupt arbiter: eligibility, priority, request hold until ack, post-ack hold-off.
// Optional sticky edge-latched external interrupt: E203_IRQ_ARB_EXT_LATCH_EN.
module e203_irq_arbiter
  import e203_irq_arb_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYC = 4,
  parameter int unsigned CNT_W       = 4
) (
  input logic                clk,
  input logic                rst,
  e203_irq_arbiter_if.slave  irq_if
);

  arb_state_e       state_q, state_d;
  logic             req_q, req_d;
  logic             dbg_q, dbg_d;
  logic [3:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ext_src;
  logic [3:0]       elig;
  logic [3:0]       sel_grant, sel_cause;
  logic             sel_dbg;
  logic [3:0]       wd_grant, wd_cause;
  logic             wd_dbg;
  logic             still_elig;

`ifdef E203_IRQ_ARB_EXT_LATCH_EN
  logic ext_prev_q;
  logic ext_pend_q, ext_pend_d;

  // A fresh edge in the ack cycle keeps the pending bit set.
  always_comb begin
    ext_pend_d = (irq_if.ext_irq_r & ~ext_prev_q)
               | (ext_pend_q & ~((state_q == ST_REQ) & irq_if.irq_ack & ~dbg_q
                                 & (cause_q == CAUSE_MEI)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_prev_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else begin
      ext_prev_q <= irq_if.ext_irq_r;
      ext_pend_q <= ext_pend_d;
    end
  end

  assign ext_src = ext_pend_q;
`else
  assign ext_src = irq_if.ext_irq_r;
`endif

  always_comb begin
    elig          = '0;
    elig[SRC_DBG] = irq_if.dbg_irq_r & ~irq_if.dbg_mode;
    elig[SRC_EXT] = ext_src & irq_if.mie_meie & irq_if.mstatus_mie & ~irq_if.dbg_mode;
    elig[SRC_SFT] = irq_if.sft_irq_r & irq_if.mie_msie & irq_if.mstatus_mie & ~irq_if.dbg_mode;
    elig[SRC_TMR] = irq_if.tmr_irq_r & irq_if.mie_mtie & irq_if.mstatus_mie & ~irq_if.dbg_mode;
  end

  e203_irq_prio_sel u_sel (
    .elig_i   (elig),
    .grant_o  (sel_grant),
    .cause_o  (sel_cause),
    .is_dbg_o (sel_dbg)
  );

  // Same selector restricted to the latched source: it still wins only if still eligible.
  e203_irq_prio_sel u_wd (
    .elig_i   (elig & src_mask(dbg_q, cause_q)),
    .grant_o  (wd_grant),
    .cause_o  (wd_cause),
    .is_dbg_o (wd_dbg)
  );

  assign still_elig = (|wd_grant) & (wd_cause == cause_q) & (wd_dbg == dbg_q);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dbg_d   = dbg_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|sel_grant) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          dbg_d   = sel_dbg;
          cause_d = sel_cause;
        end
      end
      ST_REQ: begin
        if (irq_if.irq_ack) begin
          req_d   = 1'b0;
          dbg_d   = 1'b0;
          cause_d = CAUSE_NONE;
          if (HOLDOFF_CYC > 0) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(HOLDOFF_CYC);
          end else begin
            state_d = ST_IDLE;
          end
        end else if (!still_elig) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          dbg_d   = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        dbg_d   = 1'b0;
        cause_d = CAUSE_NONE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      dbg_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dbg_q   <= dbg_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign irq_if.irq_req    = req_q;
  assign irq_if.irq_is_dbg = dbg_q;
  assign irq_if.irq_cause  = cause_q;

endmodule
